// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle between a producer and the UART transmitter.
interface uart_tx_fifo_if;
    logic [7:0] din;
    logic       din_valid;
    logic       tx;
    logic       tx_busy;
    logic       tx_active;
    logic       overflow;

    modport master (output din, din_valid, input tx, tx_busy, tx_active, overflow);
    modport slave  (input din, din_valid, output tx, tx_busy, tx_active, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter; tx falls two edges after a push into an idle, empty block.
// tx_busy warns the producer early; a push into a full FIFO is dropped and latches overflow.
module uart_tx_fifo #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int BUSY_MARGIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(DIV);

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BUSY_AT   = CNT_W'(FIFO_DEPTH - BUSY_MARGIN);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, overflow_q;

    state_t           state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             tx_q, tx_n, baud_wrap;

    assign push          = bus.din_valid && (count != FULL);
    assign baud_wrap     = (baud_cnt == BAUD_LAST);
    assign bus.tx        = tx_q;
    assign bus.tx_busy   = (count >= BUSY_AT);
    assign bus.tx_active = (state != IDLE);
    assign bus.overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // a pop in the same cycle does not make room for a push into a full FIFO
            if (bus.din_valid && count == FULL) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle
    always_comb begin
        state_n = state;
        baud_n  = baud_wrap ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_wrap) begin
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                tx_n = shift[bit_idx];
                if (baud_wrap) begin
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        bit_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
